// File: rtl/mem_stage_pkg.sv
// Shared ISA opcodes, FSM state encodings and access-classification helpers
// for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LD   = 6'h27;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_SD   = 6'h2F;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_REQ2  = 3'd3;
  localparam logic [2:0] S_RESP2 = 3'd4;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  // Natural alignment: word on 4, halfword on 2, double on 8 bytes.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [2:0] a);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW: bad = (a[1:0] != 2'b00);
      OP_LH, OP_SH: bad = a[0];
      OP_LD, OP_SD: bad = (a != 3'b000);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and write-data replication
// for stores, halfword selection and sign extension for loads.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       op,
  input  logic             half_sel,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data
);

  logic [15:0] half;

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    half      = half_sel ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_SH: begin
        be    = half_sel ? 4'b1100 : 4'b0011;
        wdata = {store_data[15:0], store_data[15:0]};
      end
      OP_LH: load_data = {{(WIDTH-16){half[15]}}, half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: passes non-memory instructions through and
// runs one- or two-beat req/gnt/rvalid transactions for loads and stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic [WIDTH-1:0] LMD,
  output logic [WIDTH-1:0] LMD_hi,
  output logic             IsStall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] NOP_IR = {OP_NOP, {(WIDTH-6){1'b0}}};

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ir_q, z_q, addr_q, lmd_lo_q;
  logic [WIDTH-3:0] pc_q;

  logic [5:0]       op_in, op_q, align_op;
  logic             align_half;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata, al_load, addr_next;
  logic             finish, abort, tmo_hit;

  assign op_in     = IR_in[WIDTH-1 -: 6];
  assign op_q      = ir_q[WIDTH-1 -: 6];
  assign addr_next = {addr_q[WIDTH-1:2] + (WIDTH-2)'(1), 2'b00};

  // In IDLE the lanes are computed for the incoming request; afterwards they
  // serve load extraction for the latched instruction.
  assign align_op   = (state == S_IDLE) ? op_in : op_q;
  assign align_half = (state == S_IDLE) ? Addr_in[1] : addr_q[1];

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .op         (align_op),
    .half_sel   (align_half),
    .store_data ((state == S_IDLE) ? Z_in : z_q),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    finish  = 1'b0;
    abort   = 1'b0;
    tmo_hit = (cnt == TMO_LAST);
    case (state)
      S_REQ:   if (mem_gnt)    finish = is_store_op(op_q) && (op_q != OP_SD);
               else            abort  = tmo_hit;
      S_RESP:  if (mem_rvalid) finish = (op_q != OP_LD);
               else            abort  = tmo_hit;
      S_REQ2:  if (mem_gnt)    finish = (op_q == OP_SD);
               else            abort  = tmo_hit;
      S_RESP2: if (mem_rvalid) finish = 1'b1;
               else            abort  = tmo_hit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ir_q         <= NOP_IR;
      pc_q         <= '0;
      z_q          <= '0;
      addr_q       <= '0;
      lmd_lo_q     <= '0;
      IR_out       <= NOP_IR;
      PC_out       <= '0;
      Z_out        <= '0;
      LMD          <= '0;
      LMD_hi       <= '0;
      IsStall      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!is_mem_op(op_in)) begin
            IR_out <= IR_in;
            PC_out <= PC_in;
            Z_out  <= Z_in;
          end else if (is_misaligned(op_in, Addr_in[2:0])) begin
            IR_out       <= NOP_IR;
            PC_out       <= PC_in;
            Z_out        <= Z_in;
            misalign_err <= 1'b1;
          end else begin
            ir_q      <= IR_in;
            pc_q      <= PC_in;
            z_q       <= Z_in;
            addr_q    <= Addr_in;
            IsStall   <= 1'b1;
            state     <= S_REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store_op(op_in);
            mem_addr  <= {Addr_in[WIDTH-1:2], 2'b00};
            mem_be    <= al_be;
            mem_wdata <= al_wdata;
          end
        end
        S_REQ, S_REQ2: begin
          if (mem_gnt) begin
            cnt     <= '0;
            mem_req <= 1'b0;
            if (state == S_REQ && op_q == OP_SD) begin
              state     <= S_REQ2;
              mem_req   <= 1'b1;
              mem_addr  <= addr_next;
              mem_be    <= 4'b1111;
              mem_wdata <= '0;
            end else if (is_load_op(op_q)) begin
              state <= (state == S_REQ) ? S_RESP : S_RESP2;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            cnt <= '0;
            if (op_q == OP_LD) begin
              lmd_lo_q <= mem_rdata;
              state    <= S_REQ2;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr_next;
              mem_be   <= 4'b1111;
            end else begin
              LMD <= al_load;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP2: begin
          if (mem_rvalid) begin
            LMD    <= lmd_lo_q;
            LMD_hi <= mem_rdata;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      // Completion and abort override whatever the state arm scheduled.
      if (finish) begin
        IR_out  <= ir_q;
        PC_out  <= pc_q;
        Z_out   <= z_q;
        IsStall <= 1'b0;
        state   <= S_IDLE;
        cnt     <= '0;
      end
      if (abort) begin
        IR_out  <= NOP_IR;
        IsStall <= 1'b0;
        mem_req <= 1'b0;
        bus_err <= 1'b1;
        state   <= S_IDLE;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions, a scripted memory
// responder that checks each granted request, and an output monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic [31:0] ir;
    logic [29:0] pc;
    logic [31:0] z, lmd, lmd_hi;
    logic        chk_z, chk_lmd, chk_hi, mis, berr;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we, chk_wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] IR_in = '0, Z_in = '0, Addr_in = '0;
  logic [29:0] PC_in = '0;
  logic [31:0] IR_out, Z_out, LMD, LMD_hi, mem_addr, mem_wdata;
  logic [29:0] PC_out;
  logic        IsStall, mem_req, mem_we, misalign_err, bus_err;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  req_t req_q[$];
  logic [31:0] rdata_q[$];
  logic [29:0] pc_out_model = '0;
  int gnt_wait = 0;
  int rv_wait  = 0;

  mem_stage #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in),
    .Addr_in(Addr_in), .IR_out(IR_out), .PC_out(PC_out), .Z_out(Z_out),
    .LMD(LMD), .LMD_hi(LMD_hi), .IsStall(IsStall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectOut(input logic [31:0] ir, input logic [29:0] pc, input logic [31:0] z,
                           input logic chk_z, input logic [31:0] lmd, input logic chk_lmd,
                           input logic [31:0] hi, input logic chk_hi, input logic mis,
                           input logic berr);
    exp_t e;
    e.ir = ir; e.pc = pc; e.z = z; e.chk_z = chk_z; e.lmd = lmd; e.chk_lmd = chk_lmd;
    e.lmd_hi = hi; e.chk_hi = chk_hi; e.mis = mis; e.berr = berr;
    exp_q.push_back(e);
    pc_out_model = pc;
  endtask

  task automatic expectReq(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic chk_wdata);
    req_t r;
    r.addr = addr; r.we = we; r.be = be; r.wdata = wdata; r.chk_wdata = chk_wdata;
    req_q.push_back(r);
  endtask

  // Issue one instruction, hold it while stalled, then idle on a NOP whose
  // PC matches the expected PC_out so the idle cycle is not seen as output.
  task automatic applyStimulus(input string name, input logic [31:0] ir, input logic [29:0] pc,
                               input logic [31:0] z, input logic [31:0] addr,
                               input int exp_stall, input int exp_req_cycles);
    int stall_cnt, req_cnt, n;
    logic done;
    @(negedge clk);
    IR_in = ir; PC_in = pc; Z_in = z; Addr_in = addr;
    stall_cnt = 0; req_cnt = 0; done = 1'b0;
    @(posedge clk);
    for (n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (IsStall) stall_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_stall_bound: IsStall still high after 200 cycles", name);
    end
    IR_in = {OP_NOP, 26'b0}; PC_in = pc_out_model; Z_in = '0; Addr_in = '0;
    checkOutput({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    checkOutput({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req_cycles));
  endtask

  // Memory responder: grants after gnt_wait cycles (never if negative) and
  // returns read data rv_wait cycles after a read grant.
  initial begin
    int req_age, rv_count;
    req_t r;
    req_age = 0; rv_count = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst_n) begin
        req_age = 0; rv_count = 0;
      end else begin
        if (rv_count > 0) begin
          rv_count--;
          if (rv_count == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hBAD0BAD0;
          end
        end
        if (!mem_req) begin
          req_age = 0;
        end else if (gnt_wait >= 0 && req_age == gnt_wait) begin
          mem_gnt = 1'b1;
          req_age = 0;
          if (req_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL req_unexpected: request at 0x%08h, none expected", mem_addr);
          end else begin
            r = req_q.pop_front();
            checkOutput("req_addr", mem_addr, r.addr);
            checkOutput("req_we", 32'(mem_we), 32'(r.we));
            checkOutput("req_be", 32'(mem_be), 32'(r.be));
            if (r.chk_wdata) checkOutput("req_wdata", mem_wdata, r.wdata);
          end
          if (!mem_we && rv_wait >= 0) rv_count = rv_wait + 1;
        end else begin
          req_age++;
        end
      end
    end
  end

  // Output monitor: an output is presented when PC_out changes or IsStall falls.
  initial begin
    logic [29:0] last_pc;
    logic        last_stall;
    exp_t e;
    last_pc = '0; last_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ((PC_out !== last_pc) || (last_stall && !IsStall))) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_unexpected: PC_out 0x%08h, no output expected", PC_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_ir", IR_out, e.ir);
          checkOutput("out_pc", 32'(PC_out), 32'(e.pc));
          checkOutput("out_misalign", 32'(misalign_err), 32'(e.mis));
          checkOutput("out_bus_err", 32'(bus_err), 32'(e.berr));
          if (e.chk_z)   checkOutput("out_z", Z_out, e.z);
          if (e.chk_lmd) checkOutput("out_lmd", LMD, e.lmd);
          if (e.chk_hi)  checkOutput("out_lmd_hi", LMD_hi, e.lmd_hi);
        end
      end
      last_pc = PC_out; last_stall = IsStall;
    end
  end

  initial begin
    logic [31:0] ir;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ir", IR_out, {OP_NOP, 26'b0});
    checkOutput("rst_pc", 32'(PC_out), 32'h0);
    checkOutput("rst_z", Z_out, 32'h0);
    checkOutput("rst_lmd", LMD, 32'h0);
    checkOutput("rst_lmd_hi", LMD_hi, 32'h0);
    checkOutput("rst_ctrl", {28'h0, IsStall, mem_req, misalign_err, bus_err}, 32'h0);
    checkOutput("rst_bus", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'h0);
    rst_n = 1'b1;

    ir = {OP_ADD, 26'h0ABC};
    expectOut(ir, 30'h10, 32'h1234, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("add", ir, 30'h10, 32'h1234, 32'h0, 0, 0);

    ir = {OP_LW, 26'h0001};
    expectReq(32'h100, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'hDEADBEEF);
    expectOut(ir, 30'h11, 32'h55, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    applyStimulus("lw", ir, 30'h11, 32'h55, 32'h100, 2, 1);

    ir = {OP_LH, 26'h0002};
    expectReq(32'h100, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'h8001_7FFF);
    expectOut(ir, 30'h12, 32'h66, 1, 32'hFFFF8001, 1, 0, 0, 0, 0);
    applyStimulus("lh_hi", ir, 30'h12, 32'h66, 32'h102, 2, 1);

    ir = {OP_LH, 26'h0003};
    expectReq(32'h100, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'h8001_7FFF);
    expectOut(ir, 30'h13, 32'h77, 1, 32'h00007FFF, 1, 0, 0, 0, 0);
    applyStimulus("lh_lo", ir, 30'h13, 32'h77, 32'h100, 2, 1);

    ir = {OP_SH, 26'h0004};
    expectReq(32'h100, 1, 4'b1100, 32'hABCDABCD, 1);
    expectOut(ir, 30'h14, 32'h0000ABCD, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("sh_hi", ir, 30'h14, 32'h0000ABCD, 32'h102, 1, 1);

    ir = {OP_SH, 26'h0005};
    expectReq(32'h100, 1, 4'b0011, 32'h12341234, 1);
    expectOut(ir, 30'h15, 32'hFFFF1234, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("sh_lo", ir, 30'h15, 32'hFFFF1234, 32'h100, 1, 1);

    ir = {OP_LD, 26'h0006};
    expectReq(32'h200, 0, 4'hF, 0, 0);
    expectReq(32'h204, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'h11111111);
    rdata_q.push_back(32'h22222222);
    expectOut(ir, 30'h16, 32'h88, 1, 32'h11111111, 1, 32'h22222222, 1, 0, 0);
    applyStimulus("ld", ir, 30'h16, 32'h88, 32'h200, 4, 2);

    ir = {OP_SD, 26'h0007};
    expectReq(32'h308, 1, 4'hF, 32'hCAFEF00D, 1);
    expectReq(32'h30C, 1, 4'hF, 32'h0, 1);
    expectOut(ir, 30'h17, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("sd", ir, 30'h17, 32'hCAFEF00D, 32'h308, 2, 2);

    expectOut({OP_NOP, 26'b0}, 30'h18, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("sw_mis", {OP_SW, 26'h0008}, 30'h18, 32'h99, 32'h101, 0, 0);
    expectOut({OP_NOP, 26'b0}, 30'h19, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("lh_mis", {OP_LH, 26'h0009}, 30'h19, 32'h99, 32'h101, 0, 0);
    expectOut({OP_NOP, 26'b0}, 30'h1A, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("ld_mis", {OP_LD, 26'h000A}, 30'h1A, 32'h99, 32'h204, 0, 0);

    ir = {OP_LW, 26'h000B};
    gnt_wait = 2; rv_wait = 1;
    expectReq(32'h40, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'h0BADF00D);
    expectOut(ir, 30'h1B, 32'hAA, 1, 32'h0BADF00D, 1, 0, 0, 0, 0);
    applyStimulus("lw_slow", ir, 30'h1B, 32'hAA, 32'h40, 5, 3);

    gnt_wait = -1; rv_wait = 0;
    expectOut({OP_NOP, 26'b0}, 30'h1B, 0, 0, 32'h0BADF00D, 1, 0, 0, 0, 1);
    applyStimulus("lw_tmo", {OP_LW, 26'h000C}, 30'h1C, 32'hBB, 32'h80, 16, 16);
    gnt_wait = 0;

    ir = {OP_SW, 26'h000D};
    expectReq(32'h104, 1, 4'hF, 32'h01020304, 1);
    expectOut(ir, 30'h1D, 32'h01020304, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("sw", ir, 30'h1D, 32'h01020304, 32'h104, 1, 1);

    // Reset while a load waits in RESP.
    rv_wait = -1;
    expectReq(32'h300, 0, 4'hF, 0, 0);
    @(negedge clk);
    IR_in = {OP_LW, 26'h000E}; PC_in = 30'h1E; Z_in = 32'hCC; Addr_in = 32'h300;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resp_stall", 32'(IsStall), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(mem_req), 32'h0);
    checkOutput("midrst_stall", 32'(IsStall), 32'h0);
    checkOutput("midrst_ir", IR_out, {OP_NOP, 26'b0});
    checkOutput("midrst_lmd", LMD, 32'h0);
    IR_in = {OP_NOP, 26'b0}; PC_in = '0; Z_in = '0; Addr_in = '0;
    pc_out_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_wait = 0;

    ir = {OP_LW, 26'h000F};
    expectReq(32'h300, 0, 4'hF, 0, 0);
    rdata_q.push_back(32'hA5A5A5A5);
    expectOut(ir, 30'h1F, 32'hDD, 1, 32'hA5A5A5A5, 1, 0, 0, 0, 0);
    applyStimulus("lw_after_rst", ir, 30'h1F, 32'hDD, 32'h300, 2, 1);

    repeat (4) @(negedge clk);
    checkOutput("sb_out_drained", 32'(exp_q.size()), 32'h0);
    checkOutput("sb_req_drained", 32'(req_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
